// File: rtl/game_state_ctrl.sv
// Game-flow controller: debounced start, IDLE/PLAY/OVER sequencing, new_game pulse, level.
// Optional pause button and run gating when GAME_PAUSE_EN is defined.
module game_state_ctrl #(
   parameter int unsigned DEB_CYCLES      = 500000,
   parameter int unsigned DEB_W           = 19,
   parameter int unsigned DEAD_HOLD_TICKS = 120,
   parameter int unsigned LEVEL_TICKS     = 600,
   parameter int unsigned LVL_W           = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             start,
   input  logic             dead,
`ifdef GAME_PAUSE_EN
   input  logic             pause,
`endif
   output logic             status,
   output logic             game_over,
   output logic             new_game,
   output logic [LVL_W-1:0] level,
   output logic             run
);

`ifdef GAME_PAUSE_EN
   localparam int unsigned NBTN = 2;
`else
   localparam int unsigned NBTN = 1;
`endif
   localparam int unsigned HOLD_W = $clog2(DEAD_HOLD_TICKS + 1);
   localparam int unsigned LT_W   = $clog2(LEVEL_TICKS + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DEAD_HOLD_TICKS - 1);
   localparam logic [LT_W-1:0]   LT_LAST   = LT_W'(LEVEL_TICKS - 1);

   typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

   // Button conditioning: bit 0 is start, bit 1 (if present) is pause.
   logic [NBTN-1:0]  btn_raw;
   logic [NBTN-1:0]  sync1_q, sync2_q, stable_q, stable_dly_q, press;
   logic [DEB_W-1:0] deb_cnt_q [NBTN];

`ifdef GAME_PAUSE_EN
   assign btn_raw = {pause, start};
`else
   assign btn_raw = start;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         stable_dly_q <= stable_q;
         for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
               stable_q[i]  <= ~stable_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Rising edge of the debounced level; both terms are flops, so this is glitch-free.
   assign press = stable_q & ~stable_dly_q;

   logic start_press, frozen;
   assign start_press = press[0];

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [LT_W-1:0]   lvl_cnt_q, lvl_cnt_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              new_game_q, new_game_d;
   logic              status_q, game_over_q;
   logic              enter_play;

`ifdef GAME_PAUSE_EN
   logic pause_press, paused_q, paused_d, run_q;
   assign pause_press = press[1];
   assign frozen      = paused_q;
`else
   assign frozen      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      lvl_cnt_d  = lvl_cnt_q;
      level_d    = level_q;
      new_game_d = 1'b0;
      enter_play = 1'b0;
`ifdef GAME_PAUSE_EN
      paused_d   = paused_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_press) enter_play = 1'b1;
         end
         StPlay: begin
            if (dead) begin
               state_d = StOver;
               hold_d  = HOLD_INIT;
`ifdef GAME_PAUSE_EN
               paused_d = 1'b0;
`endif
            end else begin
`ifdef GAME_PAUSE_EN
               if (pause_press) paused_d = ~paused_q;
`endif
               if (tick && !frozen) begin
                  if (lvl_cnt_q == LT_LAST) begin
                     lvl_cnt_d = '0;
                     if (level_q != '1) level_d = level_q + 1'b1;
                  end else begin
                     lvl_cnt_d = lvl_cnt_q + 1'b1;
                  end
               end
            end
         end
         StOver: begin
            if (tick && hold_q != '0) hold_d = hold_q - 1'b1;
            // Presses during the hold window are dropped, not queued.
            if (start_press && hold_q == '0) enter_play = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (enter_play) begin
         state_d    = StPlay;
         new_game_d = 1'b1;
         level_d    = '0;
         lvl_cnt_d  = '0;
`ifdef GAME_PAUSE_EN
         paused_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         lvl_cnt_q   <= '0;
         level_q     <= '0;
         new_game_q  <= 1'b0;
         status_q    <= 1'b0;
         game_over_q <= 1'b0;
`ifdef GAME_PAUSE_EN
         paused_q    <= 1'b0;
         run_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         lvl_cnt_q   <= lvl_cnt_d;
         level_q     <= level_d;
         new_game_q  <= new_game_d;
         status_q    <= (state_d == StPlay);
         game_over_q <= (state_d == StOver);
`ifdef GAME_PAUSE_EN
         paused_q    <= paused_d;
         run_q       <= (state_d == StPlay) & ~paused_d;
`endif
      end
   end

   assign status    = status_q;
   assign game_over = game_over_q;
   assign new_game  = new_game_q;
   assign level     = level_q;
`ifdef GAME_PAUSE_EN
   assign run       = run_q;
`else
   assign run       = status_q;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios then random stimulus, all against a tick-count model.
module tb_game_state_ctrl;

   localparam int unsigned DEB = 4;
   localparam int unsigned DHT = 3;
   localparam int unsigned LT  = 5;
   localparam int unsigned LW  = 2;
`ifdef GAME_PAUSE_EN
   localparam bit PAUSE_BUILD = 1'b1;
`else
   localparam bit PAUSE_BUILD = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, dead = 1'b0, pause = 1'b0;
   logic status, game_over, new_game, run;
   logic [LW-1:0] level;

   game_state_ctrl #(
      .DEB_CYCLES(DEB), .DEB_W(3), .DEAD_HOLD_TICKS(DHT), .LEVEL_TICKS(LT), .LVL_W(LW)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .dead(dead),
`ifdef GAME_PAUSE_EN
      .pause(pause),
`endif
      .status(status), .game_over(game_over), .new_game(new_game), .level(level), .run(run)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int tick_ph = 0, ticks_total = 0;
   bit ng_seen = 1'b0;

   // Reference model: game mode plus tick counts; level and hold derive arithmetically.
   int m_mode = 0;        // 0 idle, 1 play, 2 over
   int m_pt = 0;          // unpaused ticks seen in the current game
   int m_ot = 0;          // ticks seen since entering over
   bit m_ng = 1'b0, m_paused = 1'b0;
   bit d1 [2], d2 [2], stab [2], pend [2];
   bit sh [2][DEB];       // recent synchronized samples, newest at 0
   int sn [2];

   function automatic int exp_level();
      int lv = m_pt / LT;
      return (lv > 3) ? 3 : lv;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic enter_play();
      m_mode = 1; m_pt = 0; m_ng = 1'b1; m_paused = 1'b0;
   endtask

   task automatic model_edge();
      bit pr, pp, syncv, all_diff;
      bit raw [2];
      if (reset) begin
         m_mode = 0; m_pt = 0; m_ot = 0; m_ng = 1'b0; m_paused = 1'b0;
         for (int b = 0; b < 2; b++) begin
            d1[b] = 0; d2[b] = 0; stab[b] = 0; pend[b] = 0; sn[b] = 0;
         end
      end else begin
         pr = pend[0];
         pp = pend[1] && PAUSE_BUILD;
         m_ng = 1'b0;
         case (m_mode)
            0: if (pr) enter_play();
            1: begin
               if (dead) begin
                  m_mode = 2; m_ot = 0; m_paused = 1'b0;
               end else begin
                  if (tick && !m_paused) m_pt++;
                  if (pp) m_paused = !m_paused;
               end
            end
            default: begin
               if (pr && m_ot >= DHT - 1) enter_play();
               else if (tick) m_ot++;
            end
         endcase
         raw[0] = start; raw[1] = pause;
         for (int b = 0; b < 2; b++) begin
            syncv = d2[b]; d2[b] = d1[b]; d1[b] = raw[b];
            for (int j = DEB - 1; j > 0; j--) sh[b][j] = sh[b][j-1];
            sh[b][0] = syncv;
            if (sn[b] < DEB) sn[b]++;
            pend[b] = 1'b0;
            // Flip once DEB consecutive synchronized samples disagree with the stable value.
            if (sn[b] == DEB) begin
               all_diff = 1'b1;
               for (int j = 0; j < DEB; j++) if (sh[b][j] == stab[b]) all_diff = 1'b0;
               if (all_diff) begin
                  stab[b] = !stab[b];
                  pend[b] = stab[b];
               end
            end
         end
      end
   endtask

   task automatic step();
      tick = (tick_ph == 7);
      @(posedge clk);
      model_edge();
      if (tick) ticks_total++;
      tick_ph = (tick_ph + 1) % 8;
      #1;
      if (new_game) ng_seen = 1'b1;
      chk("status", status, 8'(m_mode == 1));
      chk("game_over", game_over, 8'(m_mode == 2));
      chk("new_game", new_game, 8'(m_ng));
      chk("level", level, 8'(exp_level()));
      chk("run", run, 8'((m_mode == 1) && !m_paused));
   endtask

   task automatic until_ticks(input int t0, input int n);
      int g = 0;
      while (ticks_total - t0 < n && g < 300) begin
         step();
         g++;
      end
      chk("tick_wait", 8'(ticks_total - t0), 8'(n));
   endtask

   task automatic to_tick_cycle();
      while (tick_ph != 7) step();
   endtask

   initial begin
      int t0, t1, sl, dl, pl, lv_frozen;
      reset = 1'b1;
      repeat (3) step();
      chk("rst_status", status, 0);
      chk("rst_level", level, 0);
      reset = 1'b0;
      step();

      // Short glitches never qualify.
      for (int w = 1; w <= 3; w++) begin
         start = 1'b1; repeat (w) step();
         start = 1'b0; repeat (10) step();
      end
      chk("glitch_ng", ng_seen, 0);
      chk("glitch_status", status, 0);

      // Clean press: PLAY on the 7th clock after start rises.
      start = 1'b1;
      repeat (6) step();
      chk("pre_press_status", status, 0);
      step();
      chk("press_status", status, 1);
      chk("press_new_game", new_game, 1);
      chk("press_level", level, 0);
      t0 = ticks_total;
      step();
      chk("new_game_width", new_game, 0);
      repeat (12) step();
      start = 1'b0;
      repeat (8) step();

      // Level ramp and saturation.
      until_ticks(t0, 4);  chk("lvl_t4", level, 0);
      until_ticks(t0, 5);  chk("lvl_t5", level, 1);
      until_ticks(t0, 9);  chk("lvl_t9", level, 1);
      until_ticks(t0, 10); chk("lvl_t10", level, 2);
      until_ticks(t0, 15); chk("lvl_t15", level, 3);
      until_ticks(t0, 22); chk("lvl_t22", level, 3);

      // Death on a tick; level held on the score screen.
      to_tick_cycle();
      dead = 1'b1; step(); dead = 1'b0;
      chk("over_go", game_over, 1);
      chk("over_status", status, 0);
      chk("over_level_held", level, 3);

      // Early press is discarded.
      start = 1'b1; repeat (8) step(); start = 1'b0; repeat (8) step();
      chk("early_press_go", game_over, 1);

      // Press after the hold window restarts the game.
      t1 = ticks_total;
      until_ticks(t1, 3);
      start = 1'b1;
      repeat (6) step();
      chk("restart_pre", status, 0);
      step();
      chk("restart_status", status, 1);
      chk("restart_ng", new_game, 1);
      chk("restart_level", level, 0);
      t0 = ticks_total;
      start = 1'b0;
      repeat (8) step();

      // Dead on the level-up tick wins; level stays 0.
      until_ticks(t0, 4);
      to_tick_cycle();
      dead = 1'b1; step(); dead = 1'b0;
      chk("dead_tick_count", 8'(ticks_total - t0), 5);
      chk("dead_tick_go", game_over, 1);
      chk("dead_tick_status", status, 0);
      chk("dead_tick_level", level, 0);

      // Reset mid-debounce and mid-hold.
      start = 1'b1; repeat (2) step();
      reset = 1'b1; step();
      chk("mid_rst_status", status, 0);
      chk("mid_rst_go", game_over, 0);
      chk("mid_rst_ng", new_game, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_run", run, 0);
      reset = 1'b0;
      repeat (12) step();
      start = 1'b0;
      repeat (10) step();

`ifdef GAME_PAUSE_EN
      // Pause freezes level progress but keeps the gameplay layers selected.
      pause = 1'b1; repeat (8) step(); pause = 1'b0; repeat (8) step();
      chk("paused_run", run, 0);
      chk("paused_status", status, 1);
      lv_frozen = exp_level();
      t1 = ticks_total;
      until_ticks(t1, 10);
      chk("paused_level", level, 8'(lv_frozen));
      pause = 1'b1; repeat (8) step(); pause = 1'b0; repeat (8) step();
      chk("resumed_run", run, 1);
`else
      lv_frozen = 0;
`endif

      // Random play against the model.
      sl = 0; dl = 0; pl = 0;
      for (int i = 0; i < 3000; i++) begin
         if (sl == 0) begin
            start = 1'($urandom_range(0, 1));
            sl = $urandom_range(1, 12);
         end
         sl--;
         if (pl == 0) begin
            pause = ($urandom_range(0, 5) == 0);
            pl = $urandom_range(1, 12);
         end
         pl--;
         if (dl > 0) dl--;
         else if ($urandom_range(0, 299) == 0) dl = $urandom_range(1, 3);
         dead = (dl > 0);
         reset = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
